mc_control_fsm: RTL

- Multicycle successor to the single-cycle RISC-V control unit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and holds memory strobes until the cache completes (write-through, variable latency).
- Corrects and extends load/store size decode, flags illegal encodings, and traps on a bounded memory wait.
- Sits between the instruction/data cache interfaces and the datapath muxes, register file and PC register.

---
 rtl/mc_control_fsm.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a bounded cache wait.
// Optional MC_CONTROL_PERF_CNT_EN adds retired/stall performance counters.
module mc_control_fsm #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TMO_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       op_f7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       instr_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       pc_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic [1:0] pc_src,
  output logic [2:0] load_type,
  output logic [1:0] store_type,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout
`ifdef MC_CONTROL_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b101
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LB  = 3'b010;
  localparam logic [2:0] LT_LHU = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [1:0] ST_SW  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SB  = 2'b10;

  // Last count value at which a missing handshake still leaves us waiting.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [6:0]       opc_q, opc_d;
  logic [2:0]       f3_q, f3_d;
  logic             f7_q, f7_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             dec_illegal;
  logic             waiting;
  logic             is_load, is_store, is_branch, taken;

  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7, input logic sub_ok);
    logic [3:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000: r = (sub_ok && f7) ? ALU_SUB : ALU_ADD;
      3'b001: r = ALU_SLL;
      3'b010: r = ALU_SLT;
      3'b011: r = ALU_SLTU;
      3'b100: r = ALU_XOR;
      3'b101: r = f7 ? ALU_SRA : ALU_SRL;
      3'b110: r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opc_q     <= '0;
      f3_q      <= '0;
      f7_q      <= 1'b0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      f3_q      <= f3_d;
      f7_q      <= f7_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign is_load   = (opc_q == OP_LOAD);
  assign is_store  = (opc_q == OP_STORE);
  assign is_branch = (opc_q == OP_BRANCH);
  // BNE/BLT/BLTU take the branch when the compare result is non-zero.
  assign taken = zero ^ ((f3_q == 3'b001) || (f3_q == 3'b100) || (f3_q == 3'b110));

  // Datapath decode from the latched instruction fields.
  always_comb begin
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 1'b0;
    imm_src     = 3'b000;
    alu_control = ALU_ADD;
    load_type   = LT_LW;
    store_type  = ST_SW;
    dec_illegal = 1'b0;
    case (opc_q)
      OP_R: alu_control = alu_dec(f3_q, f7_q, 1'b1);
      OP_I: begin
        alu_src_b   = 1'b1;
        alu_control = alu_dec(f3_q, f7_q, 1'b0);
      end
      OP_LOAD: begin
        alu_src_b  = 1'b1;
        result_src = 2'b01;
        case (f3_q)
          3'b000:  load_type = LT_LB;
          3'b001:  load_type = LT_LH;
          3'b010:  load_type = LT_LW;
          3'b100:  load_type = LT_LBU;
          3'b101:  load_type = LT_LHU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        alu_src_b = 1'b1;
        imm_src   = 3'b001;
        case (f3_q)
          3'b000:  store_type = ST_SB;
          3'b001:  store_type = ST_SH;
          3'b010:  store_type = ST_SW;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        imm_src = 3'b010;
        case (f3_q)
          3'b000, 3'b001: alu_control = ALU_SUB;
          3'b100, 3'b101: alu_control = ALU_SLT;
          3'b110, 3'b111: alu_control = ALU_SLTU;
          default:        dec_illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 1'b1;
        imm_src    = 3'b011;
        result_src = 2'b10;
      end
      OP_JALR: begin
        alu_src_b  = 1'b1;
        result_src = 2'b10;
      end
      OP_LUI: begin
        alu_src_a = 2'b10;
        alu_src_b = 1'b1;
        imm_src   = 3'b100;
      end
      OP_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 1'b1;
        imm_src   = 3'b100;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Sequencing and state-gated strobes.
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    f3_d      = f3_q;
    f7_d      = f7_q;
    cnt_d     = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    waiting   = 1'b0;
    instr_req = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    case (state_q)
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) begin
          opc_d   = opcode;
          f3_d    = funct3;
          f7_d    = op_f7;
          state_d = S_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_write = 1'b1;
          pc_src   = taken ? 2'b01 : 2'b00;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_read  = is_load;
        mem_write = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (opc_q == OP_JAL)       pc_src = 2'b10;
        else if (opc_q == OP_JALR) pc_src = 2'b11;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    // A handshake on the final count cycle takes the normal path above.
    if (waiting) begin
      if (cnt_q == TMO_LAST) begin
        state_d   = S_TRAP;
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

`ifdef MC_CONTROL_PERF_CNT_EN
  logic [31:0] retired_q, stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (pc_write) retired_q <= retired_q + 32'd1;
      if (waiting)  stall_q   <= stall_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule
